// File: rtl/sam_if_prefetch_if.sv
// Prefetch bus bundle: instruction-memory port, branch redirect and decode handshake.
interface sam_if_prefetch_if #(
    parameter int unsigned AW = 5
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          br_en;
    logic [31:0]   br_target;
    logic          if_valid;
    logic          if_ready;
    logic [31:0]   if_ir;
    logic [31:0]   if_npc;
    logic [31:0]   pc;

    modport master (
        output imem_req, imem_addr, if_valid, if_ir, if_npc, pc,
        input  imem_ack, imem_rdata, br_en, br_target, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_ir, if_npc, pc,
        output imem_ack, imem_rdata, br_en, br_target, if_ready
    );
endinterface

// File: rtl/sam_if_prefetch.sv
// Instruction-fetch front end: one outstanding imem read, DEPTH-entry {ir, npc} queue, branch flush.
// Optional SAM_IF_BYPASS_EN: empty-queue acks go straight to decode in the ack cycle.
module sam_if_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AW       = 5,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input logic             clk,
    input logic             RN,
    sam_if_prefetch_if.master bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } entry_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          req_q, req_d;
    logic [CW-1:0] count_q, count_d, cnt_after_pop;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic          valid_q, valid_d;
    entry_t        head_q, head_d;
    entry_t        push_entry;
    entry_t        mem_q [DEPTH];
    logic          push, pop, bypass;

    // Next-state, fetch issue and queue bookkeeping
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        req_d      = req_q;
        push       = 1'b0;
        bypass     = 1'b0;
        push_entry = '{ir: bus.imem_rdata, npc: req_pc_q + 32'd1};
        pop        = valid_q && bus.if_ready && !bus.br_en;
`ifdef SAM_IF_BYPASS_EN
        bypass     = (state_q == WAIT) && bus.imem_ack && !bus.br_en &&
                     (count_q == '0) && bus.if_ready;
`endif

        unique case (state_q)
            FETCH: begin
                if (!bus.br_en && (count_q < CW'(DEPTH))) begin
                    req_d    = 1'b1;
                    req_pc_d = pc_q;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (bus.br_en) begin
                    req_d   = !bus.imem_ack;
                    state_d = bus.imem_ack ? FETCH : DRAIN;
                end else if (bus.imem_ack) begin
                    push = !bypass;
                    pc_d = pc_q + 32'd1;
                    // Re-issue straight away so an always-acking memory streams one word per cycle
                    if ((count_q + CW'(push)) < CW'(DEPTH)) begin
                        req_d    = 1'b1;
                        req_pc_d = pc_q + 32'd1;
                        state_d  = WAIT;
                    end else begin
                        req_d   = 1'b0;
                        state_d = FETCH;
                    end
                end
            end
            DRAIN: begin
                if (bus.imem_ack) begin
                    req_d   = 1'b0;
                    state_d = FETCH;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = FETCH;
            end
        endcase

        if (bus.br_en) begin
            pc_d = bus.br_target;
        end

        wr_ptr_d      = wr_ptr_q + PW'(push);
        rd_ptr_d      = rd_ptr_q + PW'(pop);
        cnt_after_pop = count_q - CW'(pop);
        count_d       = cnt_after_pop + CW'(push);
        if (bus.br_en) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        valid_d = (count_d != '0);
        head_d  = head_q;
        // New head is the word being pushed when nothing else remains in the queue
        if (count_d != '0) begin
            head_d = (cnt_after_pop == '0) ? push_entry : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            req_q    <= 1'b0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            req_q    <= req_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
        end
    end

    // Queue storage needs no reset: count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = req_pc_q[AW-1:0];
    assign bus.pc        = pc_q;

`ifdef SAM_IF_BYPASS_EN
    assign bus.if_valid = valid_q | bypass;
    assign bus.if_ir    = bypass ? push_entry.ir  : head_q.ir;
    assign bus.if_npc   = bypass ? push_entry.npc : head_q.npc;
`else
    assign bus.if_valid = valid_q;
    assign bus.if_ir    = head_q.ir;
    assign bus.if_npc   = head_q.npc;
`endif
endmodule
